// File: rtl/spi_byte_capture_pkg.sv
// Shared definitions for the SPI byte capture front end: SPI mode
// encodings, the default word size and the capture FSM state encoding.
package spi_byte_capture_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;

    typedef enum logic [1:0] {
        SPI_MODE_0 = 2'd0,
        SPI_MODE_1 = 2'd1,
        SPI_MODE_2 = 2'd2,
        SPI_MODE_3 = 2'd3
    } spi_mode_t;

    // Downstream MITM logic and injector decode these same values.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    function automatic spi_mode_t spi_mode(input bit cpol, input bit cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

    // Data is sampled on rising SCLK when CPOL == CPHA, falling otherwise.
    function automatic bit sample_on_rise(input spi_mode_t mode);
        return (mode == SPI_MODE_0) || (mode == SPI_MODE_3);
    endfunction

endpackage

// File: rtl/spi_byte_capture_if.sv
// Tapped SPI lines in, captured words and status strobes out.
interface spi_byte_capture_if
    import spi_byte_capture_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) ();

    logic                 sclk_in;
    logic                 cs_n_in;
    logic                 mosi_in;
    logic                 miso_in;
    logic [DATA_SIZE-1:0] real_mosi_data;
    logic [DATA_SIZE-1:0] real_miso_data;
    logic                 eval;
    logic                 frame_abort;
    logic                 busy;

    modport master (
        output sclk_in, cs_n_in, mosi_in, miso_in,
        input  real_mosi_data, real_miso_data, eval, frame_abort, busy
    );

    modport slave (
        input  sclk_in, cs_n_in, mosi_in, miso_in,
        output real_mosi_data, real_miso_data, eval, frame_abort, busy
    );

endinterface

// File: rtl/spi_byte_capture_sync_edge_detect.sv
// Two-flop synchronizer plus one reference flop; rise/fall are registered
// so a pin edge is reported exactly three clocks after it happens.
module sync_edge_detect (
    input  logic clk,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // [1:0] synchronize, [2] is the previous-level reference.
    // Left unreset on purpose: a reset must never fabricate an edge.
    logic [2:0] pipe_reg;
    logic       rise_reg;
    logic       fall_reg;

    always_ff @(posedge clk) begin
        pipe_reg <= {pipe_reg[1:0], async_in};
        rise_reg <= pipe_reg[1] & ~pipe_reg[2];
        fall_reg <= ~pipe_reg[1] & pipe_reg[2];
    end

    assign level = pipe_reg[2];
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi_byte_capture.sv
// Passive SPI sniffer: deserializes MOSI and MISO words in the sys_clk
// domain and strobes eval for every completed word.
module spi_byte_capture
    import spi_byte_capture_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              sys_clk,
    input logic              rst,
    spi_byte_capture_if.slave bus
);

    localparam int              CNT_W       = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_SIZE - 1);
    localparam bit              SAMPLE_RISE = sample_on_rise(spi_mode(CPOL, CPHA));

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sample_edge;
    logic mosi_s, miso_s;

    sync_edge_detect u_sclk_sync (
        .clk      (sys_clk),
        .async_in (bus.sclk_in),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    sync_edge_detect u_cs_sync (
        .clk      (sys_clk),
        .async_in (bus.cs_n_in),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Data lines get the same three-flop depth so they line up with the
    // registered SCLK edge strobe.
    logic [1:0] data_pin;
    logic [1:0] data_sync;
    assign data_pin = {bus.miso_in, bus.mosi_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_data_sync
        logic [2:0] pipe_reg;
        always_ff @(posedge sys_clk) begin
            pipe_reg <= {pipe_reg[1:0], data_pin[gi]};
        end
        assign data_sync[gi] = pipe_reg[2];
    end

    assign mosi_s = data_sync[0];
    assign miso_s = data_sync[1];

    // An edge that leaves SCLK at the sampling level is a sample edge.
    assign sample_edge = (sclk_rise | sclk_fall) && (sclk_level == SAMPLE_RISE);

    function automatic logic [DATA_SIZE-1:0] shift_in(input logic [DATA_SIZE-1:0] word,
                                                      input logic din);
        if (MSB_FIRST) begin
            return {word[DATA_SIZE-2:0], din};
        end
        return {din, word[DATA_SIZE-1:1]};
    endfunction

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [DATA_SIZE-1:0] mosi_sr_reg;
    logic [DATA_SIZE-1:0] miso_sr_reg;
    logic [DATA_SIZE-1:0] mosi_out_reg;
    logic [DATA_SIZE-1:0] miso_out_reg;
    logic                 eval_reg;
    logic                 abort_reg;
    logic                 busy_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            mosi_sr_reg  <= '0;
            miso_sr_reg  <= '0;
            mosi_out_reg <= '0;
            miso_out_reg <= '0;
            eval_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            eval_reg  <= 1'b0;
            abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Only a real falling edge opens a frame, so a reset in
                    // the middle of a frame waits for the next one.
                    if (cs_fall) begin
                        state_reg <= ST_SHIFT;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        abort_reg <= (cnt_reg != '0);
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (sample_edge) begin
                        mosi_sr_reg <= shift_in(mosi_sr_reg, mosi_s);
                        miso_sr_reg <= shift_in(miso_sr_reg, miso_s);
                        if (cnt_reg == LAST_BIT) begin
                            mosi_out_reg <= shift_in(mosi_sr_reg, mosi_s);
                            miso_out_reg <= shift_in(miso_sr_reg, miso_s);
                            eval_reg     <= 1'b1;
                            cnt_reg      <= '0;
                            state_reg    <= ST_EMIT;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (cs_level) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_SHIFT;
                        if (sample_edge) begin
                            mosi_sr_reg <= shift_in(mosi_sr_reg, mosi_s);
                            miso_sr_reg <= shift_in(miso_sr_reg, miso_s);
                            cnt_reg     <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.real_mosi_data = mosi_out_reg;
    assign bus.real_miso_data = miso_out_reg;
    assign bus.eval           = eval_reg;
    assign bus.frame_abort    = abort_reg;
    assign bus.busy           = busy_reg;

endmodule

// File: tb/tb_spi_byte_capture.sv
// Bench for spi_byte_capture: a mode-0 MSB-first build and a mode-3
// LSB-first build share one SPI driver; a scoreboard checks every strobe.
`timescale 1ns/1ps
module tb_spi_byte_capture;

    localparam int H = 5;  // sys_clk cycles per SCLK phase

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic tb_sclk = 1'b0;
    logic tb_cs_n = 1'b1;
    logic tb_mosi = 1'b0;
    logic tb_miso = 1'b0;
    bit   sel     = 1'b0;  // 0: drive the mode-0 build, 1: the mode-3 build

    spi_byte_capture_if #(.DATA_SIZE(8)) bus0 ();
    spi_byte_capture_if #(.DATA_SIZE(8)) bus3 ();

    assign bus0.sclk_in = sel ? 1'b0 : tb_sclk;
    assign bus0.cs_n_in = sel ? 1'b1 : tb_cs_n;
    assign bus0.mosi_in = tb_mosi;
    assign bus0.miso_in = tb_miso;
    assign bus3.sclk_in = sel ? tb_sclk : 1'b1;
    assign bus3.cs_n_in = sel ? tb_cs_n : 1'b1;
    assign bus3.mosi_in = tb_mosi;
    assign bus3.miso_in = tb_miso;

    spi_byte_capture #(.DATA_SIZE(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus0)
    );

    spi_byte_capture #(.DATA_SIZE(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus3)
    );

    typedef struct {
        bit         is_abort;
        logic [7:0] mo;
        logic [7:0] mi;
        int         due;
    } exp_t;

    exp_t       q0[$];
    exp_t       q3[$];
    logic [7:0] last_mo [2];
    logic [7:0] last_mi [2];
    logic [7:0] fm [4];
    logic [7:0] fs [4];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [7:0] cur_mo();
        return sel ? bus3.real_mosi_data : bus0.real_mosi_data;
    endfunction
    function automatic logic [7:0] cur_mi();
        return sel ? bus3.real_miso_data : bus0.real_miso_data;
    endfunction
    function automatic logic cur_busy();
        return sel ? bus3.busy : bus0.busy;
    endfunction

    task automatic expect_event(input bit is_abort, input logic [7:0] mo, input logic [7:0] mi,
                                input int due);
        exp_t e;
        e.is_abort = is_abort;
        e.mo       = mo;
        e.mi       = mi;
        e.due      = due;
        if (sel) q3.push_back(e);
        else     q0.push_back(e);
        if (!is_abort) begin
            last_mo[sel] = mo;
            last_mi[sel] = mi;
        end
    endtask

    // Monitor: every eval/frame_abort pulse consumes one scoreboard entry.
    task automatic observe(input int id, input logic ev, input logic ab,
                           input logic [7:0] mo, input logic [7:0] mi);
        exp_t  e;
        string tag;
        int    depth;
        tag   = (id == 0) ? "m0" : "m3";
        depth = (id == 0) ? q0.size() : q3.size();
        if (ev || ab) begin
            check({tag, "_eval_and_abort"}, 32'(ev & ab), 32'd0);
            if (depth == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected: eval=%0b frame_abort=%0b at cycle %0d, none expected",
                         tag, ev, ab, cyc);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q3.pop_front();
                check({tag, "_kind_abort"}, 32'(ab), 32'(e.is_abort));
                check({tag, "_cycle"}, cyc, e.due);
                if (!e.is_abort) begin
                    check({tag, "_mosi"}, 32'(mo), 32'(e.mo));
                    check({tag, "_miso"}, 32'(mi), 32'(e.mi));
                end
            end
        end
    endtask

    always @(negedge sys_clk) begin
        observe(0, bus0.eval, bus0.frame_abort, bus0.real_mosi_data, bus0.real_miso_data);
        observe(1, bus3.eval, bus3.frame_abort, bus3.real_mosi_data, bus3.real_miso_data);
    end

    // One bit: sample edge lands exactly H cycles after the call.
    task automatic drive_bit(input logic mo, input logic mi, input bit with_cs_rise);
        if (sel) tb_sclk = 1'b0;
        tb_mosi = mo;
        tb_miso = mi;
        wait_cyc(H);
        tb_sclk = 1'b1;
        if (with_cs_rise) tb_cs_n = 1'b1;
        wait_cyc(H);
        if (!sel) tb_sclk = 1'b0;
    endtask

    // Frame of nwords full words plus tail loose bits taken from fm/fs.
    // With collide, CS_N rises together with the final sample edge, so that
    // bit never counts. Words completed -> eval; leftover bits -> abort.
    task automatic send_frame(input int nwords, input int tail, input bit collide);
        int         total;
        int         w;
        int         p;
        bit         last_col;
        logic [7:0] wm;
        logic [7:0] ws;
        total   = nwords * 8 + tail;
        tb_cs_n = 1'b0;
        wait_cyc(H);
        for (int b = 0; b < total; b++) begin
            w        = b / 8;
            p        = b % 8;
            last_col = collide && (b == total - 1);
            wm       = fm[w];
            ws       = fs[w];
            if (last_col) begin
                if (p != 0) expect_event(1'b1, 8'h00, 8'h00, cyc + H + 4);
            end else if (p == 7) begin
                expect_event(1'b0, wm, ws, cyc + H + 4);
            end
            drive_bit(sel ? wm[p] : wm[7 - p], sel ? ws[p] : ws[7 - p], last_col);
        end
        if (!collide) begin
            wait_cyc(H);
            check("busy_in_frame", 32'(cur_busy()), 32'd1);
            if ((total % 8) != 0) expect_event(1'b1, 8'h00, 8'h00, cyc + 4);
            tb_cs_n = 1'b1;
        end
        wait_cyc(2 * H);
        check("busy_after_cs", 32'(cur_busy()), 32'd0);
        check("hold_mosi", 32'(cur_mo()), 32'(last_mo[sel]));
        check("hold_miso", 32'(cur_mi()), 32'(last_mi[sel]));
    endtask

    task automatic random_frames(input int n, input bit allow_collide);
        int nw;
        int tl;
        bit col;
        for (int i = 0; i < n; i++) begin
            nw  = $urandom_range(1, 3);
            tl  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            col = allow_collide && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                fm[k] = 8'($urandom);
                fs[k] = 8'($urandom);
            end
            send_frame(nw, tl, col);
        end
    endtask

    initial begin
        last_mo[0] = 8'h00; last_mo[1] = 8'h00;
        last_mi[0] = 8'h00; last_mi[1] = 8'h00;
        wait_cyc(6);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_m0_mosi", 32'(bus0.real_mosi_data), 32'd0);
        check("rst_m0_miso", 32'(bus0.real_miso_data), 32'd0);
        check("rst_m0_busy", 32'(bus0.busy), 32'd0);
        check("rst_m0_eval", 32'(bus0.eval), 32'd0);
        check("rst_m0_abort", 32'(bus0.frame_abort), 32'd0);
        check("rst_m3_mosi", 32'(bus3.real_mosi_data), 32'd0);
        check("rst_m3_miso", 32'(bus3.real_miso_data), 32'd0);
        check("rst_m3_busy", 32'(bus3.busy), 32'd0);

        // Mode 0, MSB first: single word
        fm[0] = 8'hA3; fs[0] = 8'h01;
        send_frame(1, 0, 1'b0);
        // Two words under one CS_N
        fm[0] = 8'h40; fs[0] = 8'hFF; fm[1] = 8'h5A; fs[1] = 8'hC3;
        send_frame(2, 0, 1'b0);
        // Abort after a good capture, then recover
        fm[0] = 8'hA3; fs[0] = 8'h01;
        send_frame(1, 0, 1'b0);
        fm[0] = 8'hE7; fs[0] = 8'h18;
        send_frame(0, 5, 1'b0);
        fm[0] = 8'h12; fs[0] = 8'h34;
        send_frame(1, 0, 1'b0);
        // Last sample edge coincides with CS_N rise
        fm[0] = 8'h99; fs[0] = 8'h66;
        send_frame(1, 0, 1'b1);

        random_frames(8, 1'b1);

        // Reset three bits into a word, keep clocking under the same CS_N
        fm[0] = 8'h6B; fs[0] = 8'h92;
        tb_cs_n = 1'b0;
        wait_cyc(H);
        for (int b = 0; b < 3; b++) drive_bit(fm[0][7 - b], fs[0][7 - b], 1'b0);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        last_mo[0] = 8'h00; last_mo[1] = 8'h00;
        last_mi[0] = 8'h00; last_mi[1] = 8'h00;
        for (int b = 0; b < 13; b++) drive_bit(1'($urandom), 1'($urandom), 1'b0);
        wait_cyc(H);
        check("rstmid_mosi", 32'(bus0.real_mosi_data), 32'd0);
        check("rstmid_miso", 32'(bus0.real_miso_data), 32'd0);
        check("rstmid_busy", 32'(bus0.busy), 32'd0);
        tb_cs_n = 1'b1;
        wait_cyc(2 * H);
        fm[0] = 8'hC5; fs[0] = 8'h3C;
        send_frame(1, 0, 1'b0);

        // Mode 3, LSB first
        tb_sclk = 1'b1;
        sel     = 1'b1;
        wait_cyc(2 * H);
        fm[0] = 8'h81; fs[0] = 8'h7E;
        send_frame(1, 0, 1'b0);
        random_frames(6, 1'b1);

        wait_cyc(20);
        check("sb_m0_drained", q0.size(), 32'd0);
        check("sb_m3_drained", q3.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
